// File: rtl/des_key_sched_pkg.sv
// Shared types, FIPS 46-3 permutation tables and rotation helpers for the DES key scheduler.
package des_pkg;

  typedef logic [27:0] des_half_t;
  typedef logic [47:0] des_subkey_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } des_state_t;

  // Entries are FIPS bit numbers (1 = MSB of the source vector).
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Index 0 holds the shift for round 1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic des_half_t des_rotl(des_half_t h, logic [1:0] n);
    return (n == 2'd2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic des_half_t des_rotr(des_half_t h, logic [1:0] n);
    return (n == 2'd2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// Key-load and subkey handshake bundle between the key register, scheduler and round datapath.
interface des_key_sched_if;

  logic                 start;
  logic                 decrypt;
  logic [63:0]          key;
  des_pkg::des_subkey_t subkey;
  logic                 subkey_valid;
  logic                 subkey_ready;
  logic [3:0]           round;
  logic                 busy;
  logic                 done;
  logic                 parity_err;

  modport master (
    input  start, decrypt, key, subkey_ready,
    output subkey, subkey_valid, round, busy, done, parity_err
  );

  modport slave (
    output start, decrypt, key, subkey_ready,
    input  subkey, subkey_valid, round, busy, done, parity_err
  );

endinterface

// File: rtl/des_key_sched_pc2.sv
// PC-2 compression permutation: 56-bit {C,D} to a 48-bit round subkey, wiring only.
module des_pc2
  import des_pkg::*;
(
  input  des_half_t   c,
  input  des_half_t   d,
  output des_subkey_t subkey
);

  logic [55:0] cd;
  assign cd = {c, d};

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[47-i] = cd[56-PC2[i]];
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key scheduler emitting K1..K16 (or K16..K1) over a valid/ready handshake.
// Optional key odd-parity checker enabled by defining DES_KEY_PARITY_CHK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; round reads 0
// ST_RUN  | subkey_valid high, one subkey per accepted handshake
// ST_DONE | one-cycle done pulse after the final acceptance
module des_key_sched
  import des_pkg::*;
(
  input logic             clk,
  input logic             rst,
  des_key_sched_if.master bus
);

  des_state_t  state;
  des_half_t   c_q, d_q;
  logic [4:0]  rnd;
  logic        dec;
  logic        valid_q, busy_q, done_q;
  logic [55:0] key_pc1;
  des_half_t   pc1_c, pc1_d;
  des_subkey_t subkey_w;
  logic [3:0]  sh_idx;
  logic [1:0]  sh;
  logic        last_round;
  logic        accept;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign key_pc1[55-i] = bus.key[64-PC1[i]];
  end
  assign pc1_c = key_pc1[55:28];
  assign pc1_d = key_pc1[27:0];

  // Encrypt shifts by the entry of the round being entered, decrypt by the one being left;
  // both collapse to a single 4-bit table index (round 16 wraps to 0, minus one gives 15).
  assign sh_idx     = dec ? (rnd[3:0] - 4'd1) : rnd[3:0];
  assign sh         = SHIFT[sh_idx];
  assign last_round = dec ? (rnd == 5'd1) : (rnd == 5'd16);
  assign accept     = valid_q && bus.subkey_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      rnd     <= '0;
      dec     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            c_q     <= bus.decrypt ? pc1_c : des_rotl(pc1_c, 2'd1);
            d_q     <= bus.decrypt ? pc1_d : des_rotl(pc1_d, 2'd1);
            rnd     <= bus.decrypt ? 5'd16 : 5'd1;
            dec     <= bus.decrypt;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (last_round) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              rnd     <= '0;
              state   <= ST_DONE;
            end else if (dec) begin
              c_q <= des_rotr(c_q, sh);
              d_q <= des_rotr(d_q, sh);
              rnd <= rnd - 5'd1;
            end else begin
              c_q <= des_rotl(c_q, sh);
              d_q <= des_rotl(d_q, sh);
              rnd <= rnd + 5'd1;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .c      (c_q),
    .d      (d_q),
    .subkey (subkey_w)
  );

  // The port is 4 bits wide, so round 16 reads as 0 while subkey_valid is high.
  assign bus.subkey       = subkey_w;
  assign bus.subkey_valid = valid_q;
  assign bus.round        = rnd[3:0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

`ifdef DES_KEY_PARITY_CHK_EN
  logic par_bad;
  logic perr_q;

  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^bus.key[8*b +: 8])) par_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perr_q <= 1'b0;
    else if (state == ST_IDLE && bus.start) perr_q <= par_bad;
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
